// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory MMIO responder: register offsets,
// STATUS field positions and the CMP reset value.
// Optional feature macro: DMEM_MMIO_TIMER_IRQ_EN (CMP register + timer_irq).
package dmem_mmio_pkg;

   // Word offsets inside the 16-word window
   localparam logic [3:0] OFF_CYCLE   = 4'h0;
   localparam logic [3:0] OFF_SCRATCH = 4'h1;
   localparam logic [3:0] OFF_TXDATA  = 4'h2;
   localparam logic [3:0] OFF_STATUS  = 4'h3;
   localparam logic [3:0] OFF_CMP     = 4'h4;

   // STATUS field positions
   localparam int STAT_EMPTY   = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_CNT_LSB = 2;
   localparam int STAT_CNT_MSB = 6;
   localparam int STAT_OVF     = 8;

   // CMP starts at all-ones so a freshly reset timer does not fire early
   localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Small transmit FIFO behind the TXDATA register. The head is presented
// combinationally from storage; a push into an empty FIFO becomes visible
// the cycle after the push (no fall-through). Storage itself is not reset,
// the head is forced to zero while empty.
module mmio_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   // A pop frees a slot on the same edge, so a push at full still lands
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Data storage, written only on an accepted push
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/dmem_mmio_responder.sv
// MMIO responder sharing the dmem bus. Claims address_dmem[11:4]==MMIO_BASE
// and answers with one-cycle read latency, like the dmem syncram.
// Registers: free-running CYCLE counter, SCRATCH, TXDATA push port into a
// TX FIFO, STATUS, and (with DMEM_MMIO_TIMER_IRQ_EN defined) CMP + timer_irq.
module dmem_mmio_responder
   import dmem_mmio_pkg::*;
#(
   parameter logic [7:0] MMIO_BASE  = 8'hFF,
   parameter int         FIFO_DEPTH = 4,
   parameter int         DATA_W     = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [11:0]       address_dmem,
   input  logic [DATA_W-1:0] data,
   input  logic              wren,
   output logic [DATA_W-1:0] q_mmio,
   output logic              mmio_hit,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
`ifdef DMEM_MMIO_TIMER_IRQ_EN
   ,
   output logic              timer_irq
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic              sel;
   logic [3:0]        offset;
   logic              wr;
   logic              push;
   logic              pop;
   logic [31:0]       cycle_cnt;
   logic [DATA_W-1:0] scratch;
   logic              overflow;
   logic [CW-1:0]     fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic [4:0]        count_field;
   logic [DATA_W-1:0] status_word;
   logic [DATA_W-1:0] rd_data;

   assign sel         = (address_dmem[11:4] == MMIO_BASE);
   assign offset      = address_dmem[3:0];
   assign wr          = sel & wren;
   assign push        = wr & (offset == OFF_TXDATA);
   assign pop         = tx_valid & tx_ready;
   assign tx_valid    = ~fifo_empty;
   assign count_field = 5'(fifo_count);

   mmio_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (DATA_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (data),
      .dout  (tx_data),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Free-running cycle counter, wraps at 2^32
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cycle_cnt <= '0;
      else        cycle_cnt <= cycle_cnt + 32'd1;
   end

   // SCRATCH register write
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                             scratch <= '0;
      else if (wr && offset == OFF_SCRATCH)   scratch <= data;
   end

   // Sticky overflow: set by a push that is dropped, cleared by STATUS write with bit 8
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         overflow <= 1'b0;
      else if (push && fifo_full && !pop)
         overflow <= 1'b1;
      else if (wr && offset == OFF_STATUS && data[STAT_OVF])
         overflow <= 1'b0;
   end

`ifdef DMEM_MMIO_TIMER_IRQ_EN
   logic [31:0] cmp;

   // CMP register; a write lands on the edge, the match below still sees the old value
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                        cmp <= CMP_RESET;
      else if (wr && offset == OFF_CMP)  cmp <= data[31:0];
   end

   // One-cycle pulse the cycle after the counter equals CMP
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) timer_irq <= 1'b0;
      else        timer_irq <= (cycle_cnt == cmp);
   end
`endif

   // STATUS word assembly; unlisted bits read as zero
   always_comb begin
      status_word                              = '0;
      status_word[STAT_EMPTY]                  = fifo_empty;
      status_word[STAT_FULL]                   = fifo_full;
      status_word[STAT_CNT_MSB:STAT_CNT_LSB]   = count_field;
      status_word[STAT_OVF]                    = overflow;
   end

   // Read mux over the register map; holes and TXDATA read as zero
   always_comb begin
      rd_data = '0;
      case (offset)
         OFF_CYCLE:   rd_data = DATA_W'(cycle_cnt);
         OFF_SCRATCH: rd_data = scratch;
         OFF_STATUS:  rd_data = status_word;
`ifdef DMEM_MMIO_TIMER_IRQ_EN
         OFF_CMP:     rd_data = DATA_W'(cmp);
`endif
         default:     rd_data = '0;
      endcase
   end

   // Registered read port: one-cycle latency, zero when the window is not selected
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q_mmio   <= '0;
         mmio_hit <= 1'b0;
      end else begin
         q_mmio   <= sel ? rd_data : '0;
         mmio_hit <= sel;
      end
   end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: a register-map vector table plus
// hand-written sequences for FIFO overflow, streaming, reset and timer.
module tb_dmem_mmio_responder;

   logic        clock;
   logic        reset;
   logic [11:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_mmio;
   logic        mmio_hit;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
`ifdef DMEM_MMIO_TIMER_IRQ_EN
   logic        timer_irq;
   localparam logic [31:0] CMP_READ = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] CMP_READ = 32'h0;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   dmem_mmio_responder dut (
      .clock        (clock),
      .reset        (reset),
      .address_dmem (address_dmem),
      .data         (data),
      .wren         (wren),
      .q_mmio       (q_mmio),
      .mmio_hit     (mmio_hit),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready)
`ifdef DMEM_MMIO_TIMER_IRQ_EN
      ,
      .timer_irq    (timer_irq)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        wr;
      logic [31:0] exp_q;
      logic        exp_hit;
   } vec_t;

   vec_t tbl [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [11:0] a, input logic [31:0] d, input logic w, input logic r);
      address_dmem = a;
      data         = d;
      wren         = w;
      tx_ready     = r;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   logic [31:0] words [6];
   logic [31:0] drain_exp [4];

   initial begin
      // register-map vectors: each row is one bus cycle, expectations are its read result
      tbl[0]  = '{12'hFF1, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1};
      tbl[1]  = '{12'hFF1, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
      tbl[2]  = '{12'hFF7, 32'h0,        1'b0, 32'h0,        1'b1};
      tbl[3]  = '{12'h100, 32'h0,        1'b0, 32'h0,        1'b0};
      tbl[4]  = '{12'h101, 32'h5,        1'b1, 32'h0,        1'b0};
      tbl[5]  = '{12'hFF1, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b1};
      tbl[6]  = '{12'hFF1, 32'h0,        1'b0, 32'h12345678, 1'b1};
      tbl[7]  = '{12'hFF9, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
      tbl[8]  = '{12'hFF2, 32'h0,        1'b0, 32'h0,        1'b1};
      tbl[9]  = '{12'hFF3, 32'h0,        1'b0, 32'h1,        1'b1};
      tbl[10] = '{12'hFF4, 32'h0,        1'b0, CMP_READ,     1'b1};
      tbl[11] = '{12'h0F1, 32'h0,        1'b0, 32'h0,        1'b0};
      tbl[12] = '{12'hEF2, 32'h1,        1'b1, 32'h0,        1'b0};
      tbl[13] = '{12'hFF3, 32'h0,        1'b0, 32'h1,        1'b1};

      for (int i = 0; i < 6; i++) words[i] = 32'hC0DE_0000 + 32'(i) * 32'h111;

      // reset state
      reset = 1'b0;
      drive(12'h000, 32'h0, 1'b0, 1'b0);
      #3;
      check("reset_q", q_mmio, 32'h0);
      check("reset_hit", {31'b0, mmio_hit}, 32'h0);
      check("reset_txvalid", {31'b0, tx_valid}, 32'h0);
      check("reset_txdata", tx_data, 32'h0);

      // CYCLE: 10 idle edges after release, the 11th edge samples counter value 10
      @(negedge clock);
      reset = 1'b1;
      repeat (10) step();
      drive(12'hFF0, 32'h0, 1'b0, 1'b0);
      step();
      check("cycle_read", q_mmio, 32'd10);
      check("cycle_hit", {31'b0, mmio_hit}, 32'h1);
      drive(12'h100, 32'h0, 1'b0, 1'b0);
      step();
      check("outside_hit", {31'b0, mmio_hit}, 32'h0);
      check("outside_q", q_mmio, 32'h0);

      // register-map table
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].addr, tbl[i].wdata, tbl[i].wr, 1'b0);
         step();
         check($sformatf("vec%0d_q", i), q_mmio, tbl[i].exp_q);
         check($sformatf("vec%0d_hit", i), {31'b0, mmio_hit}, {31'b0, tbl[i].exp_hit});
      end

      // five pushes into a 4-deep FIFO with the consumer stalled
      for (int i = 0; i < 5; i++) begin
         drive(12'hFF2, words[i], 1'b1, 1'b0);
         step();
      end
      drive(12'hFF3, 32'h0, 1'b0, 1'b0);
      step();
      check("status_overflow", q_mmio, 32'h112);
      for (int i = 0; i < 3; i++) begin
         check("head_stable", tx_data, words[0]);
         check("head_valid", {31'b0, tx_valid}, 32'h1);
         step();
      end
      drive(12'hFF3, 32'h100, 1'b1, 1'b0);
      step();
      check("status_clear_old", q_mmio, 32'h112);
      drive(12'hFF3, 32'h0, 1'b0, 1'b0);
      step();
      check("status_cleared", q_mmio, 32'h012);

      // push and pop together while full: count unchanged, no overflow
      drive(12'hFF2, words[5], 1'b1, 1'b1);
      step();
      check("pushpop_full_head", tx_data, words[1]);
      drive(12'hFF3, 32'h0, 1'b0, 1'b0);
      step();
      check("pushpop_full_status", q_mmio, 32'h012);

      // drain: order preserved including the word pushed at full
      drain_exp[0] = words[1];
      drain_exp[1] = words[2];
      drain_exp[2] = words[3];
      drain_exp[3] = words[5];
      drive(12'h000, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain%0d", i), tx_data, drain_exp[i]);
         step();
      end
      check("drained_valid", {31'b0, tx_valid}, 32'h0);

      // streaming: consumer always ready, one push per cycle
      for (int i = 0; i < 6; i++) begin
         drive(12'hFF2, 32'hA0 + 32'(i), 1'b1, 1'b1);
         step();
         check($sformatf("stream%0d_valid", i), {31'b0, tx_valid}, 32'h1);
         check($sformatf("stream%0d_data", i), tx_data, 32'hA0 + 32'(i));
      end
      drive(12'hFF3, 32'h0, 1'b0, 1'b1);
      step();
      check("stream_status_one", q_mmio, 32'h004);
      step();
      check("stream_status_empty", q_mmio, 32'h001);

      // asynchronous reset with three entries queued
      for (int i = 0; i < 3; i++) begin
         drive(12'hFF2, words[i], 1'b1, 1'b0);
         step();
      end
      drive(12'h000, 32'h0, 1'b0, 1'b0);
      step();
      check("pre_reset_valid", {31'b0, tx_valid}, 32'h1);
      reset = 1'b0;
      #2;
      check("async_reset_valid", {31'b0, tx_valid}, 32'h0);
      check("async_reset_data", tx_data, 32'h0);
      @(negedge clock);
      reset = 1'b1;
      drive(12'hFF3, 32'h0, 1'b0, 1'b0);
      step();
      check("post_reset_status", q_mmio, 32'h001);

`ifdef DMEM_MMIO_TIMER_IRQ_EN
      begin
         int edges;
         int pulses;
         int pulse_at;
         reset = 1'b0;
         #2;
         @(negedge clock);
         reset = 1'b1;
         drive(12'h000, 32'h0, 1'b0, 1'b0);
         repeat (5) step();
         drive(12'hFF4, 32'd20, 1'b1, 1'b0);
         step();
         drive(12'h000, 32'h0, 1'b0, 1'b0);
         edges    = 6;
         pulses   = 0;
         pulse_at = -1;
         for (int i = 0; i < 60; i++) begin
            step();
            edges++;
            if (timer_irq) begin
               pulses++;
               pulse_at = edges;
            end
         end
         check("timer_pulses", 32'(pulses), 32'd1);
         check("timer_pulse_edge", 32'(pulse_at), 32'd21);
         drive(12'hFF4, 32'h0, 1'b0, 1'b0);
         step();
         check("cmp_readback", q_mmio, 32'd20);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
